// File: rtl/occ_pkg.sv
// Shared definitions for the OCC link latency checker: FSM encoding and the
// default idle word / idle K flags used on the link when no data is sent.
package occ_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_RESYNC   = 3'd2,
        ST_BLIND    = 3'd3,
        ST_RUN      = 3'd4,
        ST_PASS     = 3'd5,
        ST_FAIL     = 3'd6
    } occ_state_e;

    localparam logic [15:0] OCC_IDLE_WORD = 16'h95bc;
    localparam logic [1:0]  OCC_IDLE_K    = 2'b01;

endpackage

// File: rtl/occ_link_pattern_gen.sv
// TX pattern generator: free-running timestamp, and one timestamp word every
// g_IDLE_PERIOD cycles while sending is enabled (idle words otherwise).
module occ_link_pattern_gen
    import occ_pkg::*;
#(
    parameter int                      g_DATA_WIDTH  = 16,
    parameter int                      g_K_WIDTH     = 2,
    parameter logic [g_DATA_WIDTH-1:0] g_IDLE_WORD   = g_DATA_WIDTH'(OCC_IDLE_WORD),
    parameter logic [g_K_WIDTH-1:0]    g_IDLE_KFLAGS = g_K_WIDTH'(OCC_IDLE_K),
    parameter int                      g_IDLE_PERIOD = 13
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    send_en_i,
    output logic [g_DATA_WIDTH-1:0] tx_data_o,
    output logic [g_K_WIDTH-1:0]    tx_k_o,
    output logic [g_DATA_WIDTH-1:0] timestamp_o
);

    localparam logic [g_DATA_WIDTH-1:0] TS_STEP    = {{(g_DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]              LAST_PHASE = 8'(g_IDLE_PERIOD - 1);

    logic [g_DATA_WIDTH-1:0] ts_r;
    logic [7:0]              phase_r;
    logic [g_DATA_WIDTH-1:0] tx_data_r;
    logic [g_K_WIDTH-1:0]    tx_k_r;

    // Free-running timestamp, wraps naturally at 2^g_DATA_WIDTH.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ts_r <= {g_DATA_WIDTH{1'b0}};
        end else begin
            ts_r <= ts_r + TS_STEP;
        end
    end

    // Data words carry ts_r+1 so that the word on tx_data_o equals the
    // timestamp of the cycle it is presented in.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_r   <= 8'd0;
            tx_data_r <= g_IDLE_WORD;
            tx_k_r    <= g_IDLE_KFLAGS;
        end else if (!send_en_i) begin
            phase_r   <= 8'd0;
            tx_data_r <= g_IDLE_WORD;
            tx_k_r    <= g_IDLE_KFLAGS;
        end else if (phase_r == LAST_PHASE) begin
            phase_r   <= 8'd0;
            tx_data_r <= ts_r + TS_STEP;
            tx_k_r    <= {g_K_WIDTH{1'b0}};
        end else begin
            phase_r   <= phase_r + 8'd1;
            tx_data_r <= g_IDLE_WORD;
            tx_k_r    <= g_IDLE_KFLAGS;
        end
    end

    assign tx_data_o   = tx_data_r;
    assign tx_k_o      = tx_k_r;
    assign timestamp_o = ts_r;

endmodule

// File: rtl/occ_link_latency_checker.sv
// Link latency checker: sends timestamps on TX, checks the looped-back RX stream
// for sequence/K/status errors with bounded retries, and reports min/max latency.
module occ_link_latency_checker
    import occ_pkg::*;
#(
    parameter int          g_DATA_WIDTH         = 16,
    parameter logic [31:0] g_IDLE               = {16'h0000, OCC_IDLE_WORD},
    parameter logic [3:0]  g_IDLE_K             = {2'b00, OCC_IDLE_K},
    parameter int          g_IDLE_PERIOD        = 13,
    parameter int          g_BLIND_PERIOD       = 10,
    parameter int          g_NUM_SUCCESFUL_DATA = 1000,
    parameter int          g_MAX_RETRIES        = 3,
    parameter int          g_LAT_WIDTH          = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      enable_i,
    output logic [g_DATA_WIDTH-1:0]   tx_data_o,
    output logic [g_DATA_WIDTH/8-1:0] tx_k_o,
    input  logic [g_DATA_WIDTH-1:0]   rx_data_i,
    input  logic [g_DATA_WIDTH/8-1:0] rx_k_i,
    input  logic                      rx_rdy_i,
    input  logic                      rx_remote_rdy_i,
    input  logic                      rx_synced_i,
    input  logic                      rx_buf_err_i,
    output logic                      rx_resync_o,
    output logic                      done_o,
    output logic                      fail_o,
    output logic [7:0]                retries_o,
    output logic [g_LAT_WIDTH-1:0]    latency_min_o,
    output logic [g_LAT_WIDTH-1:0]    latency_max_o
);

    localparam int                      KW         = g_DATA_WIDTH / 8;
    localparam int                      LW         = (g_LAT_WIDTH > g_DATA_WIDTH) ? g_LAT_WIDTH : g_DATA_WIDTH;
    localparam logic [g_DATA_WIDTH-1:0] IDLE_W     = g_IDLE[g_DATA_WIDTH-1:0];
    localparam logic [KW-1:0]           IDLE_KW    = g_IDLE_K[KW-1:0];
    localparam logic [g_DATA_WIDTH-1:0] PERIOD_W   = g_DATA_WIDTH'(g_IDLE_PERIOD);
    localparam logic [g_LAT_WIDTH-1:0]  LAT_ONES   = {g_LAT_WIDTH{1'b1}};
    localparam logic [g_LAT_WIDTH-1:0]  LAT_ZERO   = {g_LAT_WIDTH{1'b0}};
    localparam logic [LW-1:0]           LAT_SAT    = LW'(LAT_ONES);
    localparam logic [15:0]             BLIND_LAST = 16'(g_BLIND_PERIOD - 1);
    localparam logic [8:0]              GAP_LAST   = 9'(2 * g_IDLE_PERIOD - 1);
    localparam logic [31:0]             GOOD_LAST  = 32'(g_NUM_SUCCESFUL_DATA - 1);
    localparam logic [7:0]              MAX_RETRY  = 8'(g_MAX_RETRIES);

    occ_state_e              state_r;
    logic                    resync_r;
    logic                    done_r;
    logic                    fail_r;
    logic [7:0]              retries_r;
    logic [g_LAT_WIDTH-1:0]  lat_min_r;
    logic [g_LAT_WIDTH-1:0]  lat_max_r;
    logic [31:0]             good_r;
    logic [15:0]             blind_r;
    logic [8:0]              gap_r;
    logic                    ref_valid_r;
    logic [g_DATA_WIDTH-1:0] expected_r;

    logic                    send_en_s;
    logic [g_DATA_WIDTH-1:0] ts_s;
    logic                    is_idle_s;
    logic                    is_data_s;
    logic                    run_err_s;
    logic [g_DATA_WIDTH-1:0] lat_diff_s;
    logic [LW-1:0]           lat_wide_s;
    logic [g_LAT_WIDTH-1:0]  lat_s;

    assign send_en_s = (state_r == ST_BLIND) || (state_r == ST_RUN);

    occ_link_pattern_gen #(
        .g_DATA_WIDTH  (g_DATA_WIDTH),
        .g_K_WIDTH     (KW),
        .g_IDLE_WORD   (IDLE_W),
        .g_IDLE_KFLAGS (IDLE_KW),
        .g_IDLE_PERIOD (g_IDLE_PERIOD)
    ) u_pattern_gen (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .send_en_i   (send_en_s),
        .tx_data_o   (tx_data_o),
        .tx_k_o      (tx_k_o),
        .timestamp_o (ts_s)
    );

    // RX word classification, error detection and saturated latency of this word.
    always_comb begin
        is_idle_s  = (rx_data_i == IDLE_W) && (rx_k_i == IDLE_KW);
        is_data_s  = (rx_k_i == {KW{1'b0}}) && !is_idle_s;
        run_err_s  = (is_data_s && ref_valid_r && (rx_data_i != expected_r))
                   || (!is_idle_s && !is_data_s)
                   || rx_buf_err_i || !rx_rdy_i || !rx_remote_rdy_i || !rx_synced_i
                   || (!is_data_s && (gap_r == GAP_LAST));
        lat_diff_s = ts_s - rx_data_i;
        lat_wide_s = LW'(lat_diff_s);
        if (lat_wide_s > LAT_SAT) begin
            lat_s = LAT_ONES;
        end else begin
            lat_s = g_LAT_WIDTH'(lat_wide_s);
        end
    end

    // Check sequencer; enable_i low behaves like a synchronous return to reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            resync_r    <= 1'b0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            retries_r   <= 8'd0;
            lat_min_r   <= LAT_ONES;
            lat_max_r   <= LAT_ZERO;
            good_r      <= 32'd0;
            blind_r     <= 16'd0;
            gap_r       <= 9'd0;
            ref_valid_r <= 1'b0;
            expected_r  <= {g_DATA_WIDTH{1'b0}};
        end else if (!enable_i) begin
            state_r     <= ST_IDLE;
            resync_r    <= 1'b0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            retries_r   <= 8'd0;
            lat_min_r   <= LAT_ONES;
            lat_max_r   <= LAT_ZERO;
            good_r      <= 32'd0;
            blind_r     <= 16'd0;
            gap_r       <= 9'd0;
            ref_valid_r <= 1'b0;
            expected_r  <= {g_DATA_WIDTH{1'b0}};
        end else begin
            resync_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r   <= ST_WAIT_RDY;
                    good_r    <= 32'd0;
                    lat_min_r <= LAT_ONES;
                    lat_max_r <= LAT_ZERO;
                end
                ST_WAIT_RDY: begin
                    if (rx_rdy_i && rx_remote_rdy_i) begin
                        state_r  <= ST_RESYNC;
                        resync_r <= 1'b1;
                    end
                end
                ST_RESYNC: begin
                    if (rx_synced_i) begin
                        state_r <= ST_BLIND;
                        blind_r <= 16'd0;
                    end
                end
                ST_BLIND: begin
                    if (blind_r == BLIND_LAST) begin
                        state_r     <= ST_RUN;
                        gap_r       <= 9'd0;
                        ref_valid_r <= 1'b0;
                    end else begin
                        blind_r <= blind_r + 16'd1;
                    end
                end
                ST_RUN: begin
                    // An error takes priority over the word that would complete the count.
                    if (run_err_s) begin
                        if (retries_r < MAX_RETRY) begin
                            retries_r <= retries_r + 8'd1;
                            state_r   <= ST_WAIT_RDY;
                            good_r    <= 32'd0;
                            lat_min_r <= LAT_ONES;
                            lat_max_r <= LAT_ZERO;
                        end else begin
                            state_r <= ST_FAIL;
                            done_r  <= 1'b1;
                            fail_r  <= 1'b1;
                        end
                    end else if (is_data_s) begin
                        ref_valid_r <= 1'b1;
                        expected_r  <= rx_data_i + PERIOD_W;
                        gap_r       <= 9'd0;
                        good_r      <= good_r + 32'd1;
                        if (lat_s < lat_min_r) begin
                            lat_min_r <= lat_s;
                        end
                        if (lat_s > lat_max_r) begin
                            lat_max_r <= lat_s;
                        end
                        if (good_r == GOOD_LAST) begin
                            state_r <= ST_PASS;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        gap_r <= gap_r + 9'd1;
                    end
                end
                ST_PASS: begin
                    done_r <= 1'b1;
                end
                ST_FAIL: begin
                    done_r <= 1'b1;
                    fail_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_resync_o   = resync_r;
    assign done_o        = done_r;
    assign fail_o        = fail_r;
    assign retries_o     = retries_r;
    assign latency_min_o = lat_min_r;
    assign latency_max_o = lat_max_r;

endmodule
